// File: rtl/control_seq.sv
// ---------------------------------------------------------------------------
// control_seq
//   Registered multi-cycle control sequencer for the X9 datapath. Accepts one
//   opcode per instr_valid/instr_ready handshake, decodes it into the datapath
//   control bundle and presents that bundle from the following cycle. Memory
//   operations (lb/sb) hold their bundle for MEM_CYCLES cycles; branches stall
//   intake until br_done. flush aborts whatever is in progress.
//
// Parameters
//   OPW         ALUOp width (>= 4, 4-bit codes zero-extended)
//   MCODEBITS   instr width (>= 5, opcode is the top five bits)
//   MEM_CYCLES  cycles an lb/sb holds its controls (>= 1)
//   CNTW        issued-instruction counter width
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_valid, instr  opcode offered by fetch
//   instr_ready         sequencer accepts an opcode this cycle (state only)
//   br_done             branch resolved, releases the branch stall
//   flush               synchronous abort, highest priority
//   ctl_valid           control bundle is live this cycle
//   InstType .. ALUOp   registered datapath control bundle
//   issue_count         accepted instructions, modulo 2^CNTW
// ---------------------------------------------------------------------------
module control_seq #(
  parameter int OPW        = 4,
  parameter int MCODEBITS  = 5,
  parameter int MEM_CYCLES = 2,
  parameter int CNTW       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [MCODEBITS-1:0] instr,
  output logic                 instr_ready,
  input  logic                 br_done,
  input  logic                 flush,
  output logic                 ctl_valid,
  output logic [1:0]           InstType,
  output logic                 BranchInst,
  output logic                 MemRead,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [OPW-1:0]       ALUOp,
  output logic [CNTW-1:0]      issue_count
);

  typedef enum logic [1:0] {
    S_DECODE,
    S_MEM,
    S_BRANCH
  } state_t;

  typedef struct packed {
    logic [1:0] instType;
    logic       branch;
    logic       memRead;
    logic       memToReg;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
    logic [3:0] aluOp;
  } ctl_t;

  localparam ctl_t BUBBLE = '{instType: 2'b00, branch: 1'b0, memRead: 1'b0,
                              memToReg: 1'b0, memWrite: 1'b0, aluSrc: 1'b1,
                              regWrite: 1'b0, aluOp: 4'b1111};

  // Counter holds the cycles still to go after the current MEM cycle, so it
  // never needs to reach MEM_CYCLES itself.
  localparam int   MCW       = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;
  localparam logic MULTI_MEM = (MEM_CYCLES > 1);

  state_t          r_state;
  logic            r_valid;
  ctl_t            r_out;
  logic [MCW-1:0]  r_memLeft;
  logic [CNTW-1:0] r_count;

  logic [4:0]      w_opcode;
  ctl_t            w_dec;
  logic            w_isMem;

  assign w_opcode = instr[MCODEBITS-1 -: 5];

  // Opcode decode: start from the default ALU-type bundle and override the
  // fields each opcode class changes.
  always_comb begin
    w_dec = '{instType: 2'b00, branch: 1'b0, memRead: 1'b0, memToReg: 1'b0,
              memWrite: 1'b0, aluSrc: 1'b1, regWrite: 1'b1, aluOp: 4'b1111};
    casez (w_opcode)
      5'b00000: w_dec.aluOp = 4'b0000;
      5'b00001: w_dec.aluOp = 4'b0001;
      5'b00010: begin
        w_dec.aluOp  = 4'b0010;
        w_dec.aluSrc = 1'b0;
      end
      5'b00011: begin
        w_dec.instType = 2'b01;
        w_dec.memRead  = 1'b1;
        w_dec.memToReg = 1'b1;
        w_dec.aluOp    = 4'b0011;
      end
      5'b00100: begin
        w_dec.instType = 2'b01;
        w_dec.memWrite = 1'b1;
        w_dec.regWrite = 1'b0;
        w_dec.aluOp    = 4'b0100;
      end
      5'b00101, 5'b00110: begin
        w_dec.branch   = 1'b1;
        w_dec.regWrite = 1'b0;
        w_dec.aluOp    = 4'b1111;
      end
      5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100:
        w_dec.aluOp = w_opcode[3:0];
      5'b01101, 5'b01110: begin
        w_dec.aluOp    = w_opcode[3:0];
        w_dec.regWrite = 1'b0;
      end
      5'b01111: w_dec.aluOp = 4'b1111;
      5'b10???: begin
        w_dec.instType = 2'b11;
        w_dec.aluOp    = 4'b0101;
      end
      5'b11???: begin
        w_dec.instType = 2'b10;
        w_dec.aluOp    = 4'b0110;
      end
      default: ;
    endcase
  end

  assign w_isMem = w_dec.memRead | w_dec.memWrite;

  // Sequencer FSM with registered control bundle. A load's RegWrite is held
  // off until its final MEM cycle; with a single-cycle memory the load is
  // treated like an ALU op and keeps RegWrite in its only cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_DECODE;
      r_valid   <= 1'b0;
      r_out     <= BUBBLE;
      r_memLeft <= '0;
      r_count   <= '0;
    end else if (flush) begin
      r_state   <= S_DECODE;
      r_valid   <= 1'b0;
      r_out     <= BUBBLE;
      r_memLeft <= '0;
    end else begin
      case (r_state)
        S_DECODE: begin
          if (instr_valid) begin
            r_valid <= 1'b1;
            r_out   <= w_dec;
            r_count <= r_count + CNTW'(1);
            if (w_dec.branch) begin
              r_state <= S_BRANCH;
            end else if (w_isMem && MULTI_MEM) begin
              r_state        <= S_MEM;
              r_memLeft      <= MCW'(MEM_CYCLES - 1);
              r_out.regWrite <= 1'b0;
            end
          end else begin
            r_valid <= 1'b0;
            r_out   <= BUBBLE;
          end
        end
        S_MEM: begin
          if (r_memLeft == '0) begin
            r_state <= S_DECODE;
            r_valid <= 1'b0;
            r_out   <= BUBBLE;
          end else begin
            r_memLeft <= r_memLeft - MCW'(1);
            // Entering the final cycle: only a load (MemRead) writes back.
            if (r_memLeft == MCW'(1)) begin
              r_out.regWrite <= r_out.memRead;
            end
          end
        end
        S_BRANCH: begin
          r_valid <= 1'b0;
          r_out   <= BUBBLE;
          if (br_done) begin
            r_state <= S_DECODE;
          end
        end
        default: begin
          r_state <= S_DECODE;
          r_valid <= 1'b0;
          r_out   <= BUBBLE;
        end
      endcase
    end
  end

  assign instr_ready = (r_state == S_DECODE);
  assign ctl_valid   = r_valid;
  assign InstType    = r_out.instType;
  assign BranchInst  = r_out.branch;
  assign MemRead     = r_out.memRead;
  assign MemtoReg    = r_out.memToReg;
  assign MemWrite    = r_out.memWrite;
  assign ALUSrc      = r_out.aluSrc;
  assign RegWrite    = r_out.regWrite;
  assign ALUOp       = OPW'(r_out.aluOp);
  assign issue_count = r_count;

endmodule

// File: tb/tb_control_seq.sv
// ---------------------------------------------------------------------------
// tb_control_seq
//   Three control_seq instances share one stimulus stream:
//     dut0: MEM_CYCLES=3, CNTW=16, 5-bit instr, 4-bit ALUOp
//     dut1: MEM_CYCLES=4, CNTW=4,  7-bit instr (random low bits), 6-bit ALUOp
//     dut2: MEM_CYCLES=1, CNTW=8,  5-bit instr, 4-bit ALUOp
// ---------------------------------------------------------------------------
module tb_control_seq;

  typedef struct packed {
    logic       valid;
    logic [1:0] typ;
    logic       br;
    logic       mr;
    logic       m2r;
    logic       mw;
    logic       src;
    logic       rw;
    logic [5:0] op;
  } bun_t;

  typedef struct {
    logic       v;
    logic [4:0] op;
    logic       brd;
    logic       fl;
    bun_t       exp;
    logic       expRdy;
    int         expCnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instrValid = 1'b0;
  logic       brDone = 1'b0;
  logic       flushIn = 1'b0;
  logic [4:0] opc = 5'd0;
  logic [1:0] lowBits = 2'd0;
  logic [6:0] instrWide;

  assign instrWide = {opc, lowBits};

  always #5 clk = ~clk;

  logic        aRdy, aValid, aBr, aMr, aM2r, aMw, aSrc, aRw;
  logic [1:0]  aType;
  logic [3:0]  aOp;
  logic [15:0] aCnt;
  logic        bRdy, bValid, bBr, bMr, bM2r, bMw, bSrc, bRw;
  logic [1:0]  bType;
  logic [5:0]  bOp;
  logic [3:0]  bCnt;
  logic        cRdy, cValid, cBr, cMr, cM2r, cMw, cSrc, cRw;
  logic [1:0]  cType;
  logic [3:0]  cOp;
  logic [7:0]  cCnt;

  control_seq #(.OPW(4), .MCODEBITS(5), .MEM_CYCLES(3), .CNTW(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instrValid), .instr(opc),
    .instr_ready(aRdy), .br_done(brDone), .flush(flushIn), .ctl_valid(aValid),
    .InstType(aType), .BranchInst(aBr), .MemRead(aMr), .MemtoReg(aM2r),
    .MemWrite(aMw), .ALUSrc(aSrc), .RegWrite(aRw), .ALUOp(aOp), .issue_count(aCnt));

  control_seq #(.OPW(6), .MCODEBITS(7), .MEM_CYCLES(4), .CNTW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instrValid), .instr(instrWide),
    .instr_ready(bRdy), .br_done(brDone), .flush(flushIn), .ctl_valid(bValid),
    .InstType(bType), .BranchInst(bBr), .MemRead(bMr), .MemtoReg(bM2r),
    .MemWrite(bMw), .ALUSrc(bSrc), .RegWrite(bRw), .ALUOp(bOp), .issue_count(bCnt));

  control_seq #(.OPW(4), .MCODEBITS(5), .MEM_CYCLES(1), .CNTW(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instrValid), .instr(opc),
    .instr_ready(cRdy), .br_done(brDone), .flush(flushIn), .ctl_valid(cValid),
    .InstType(cType), .BranchInst(cBr), .MemRead(cMr), .MemtoReg(cM2r),
    .MemWrite(cMw), .ALUSrc(cSrc), .RegWrite(cRw), .ALUOp(cOp), .issue_count(cCnt));

  int tests = 0;
  int fails = 0;

  // Reference model state, one slot per instance.
  int   mcyc[3]  = '{3, 4, 1};
  int   cmask[3] = '{32'hFFFF, 32'hF, 32'hFF};
  int   memLeft[3];
  bit   brWait[3];
  bun_t memBun[3];
  bit   memIsLb[3];
  int   count[3];
  bun_t cur[3];

  function automatic bun_t mkB(bit v, bit [1:0] t, bit br, bit mr, bit m2r,
                               bit mw, bit src, bit rw, bit [3:0] op);
    return {v, t, br, mr, m2r, mw, src, rw, 2'b00, op};
  endfunction

  function automatic bun_t bubble();
    return mkB(0, 2'b00, 0, 0, 0, 0, 1, 0, 4'hF);
  endfunction

  // Instruction semantics by mnemonic class.
  function automatic bun_t refDecode(logic [4:0] o);
    bun_t d;
    int   code;
    d = mkB(1, 2'b00, 0, 0, 0, 0, 1, 1, 4'hF);
    code = int'(o);
    if (code >= 24) begin
      d.typ = 2'b10; d.op = 6'd6;
    end else if (code >= 16) begin
      d.typ = 2'b11; d.op = 6'd5;
    end else if (code == 0 || code == 1) begin
      d.op = 6'(code);
    end else if (code == 2) begin
      d.op = 6'd2; d.src = 1'b0;
    end else if (code == 3) begin
      d.typ = 2'b01; d.mr = 1'b1; d.m2r = 1'b1; d.op = 6'd3;
    end else if (code == 4) begin
      d.typ = 2'b01; d.mw = 1'b1; d.rw = 1'b0; d.op = 6'd4;
    end else if (code == 5 || code == 6) begin
      d.br = 1'b1; d.rw = 1'b0;
    end else if (code <= 12) begin
      d.op = 6'(code);
    end else if (code <= 14) begin
      d.op = 6'(code); d.rw = 1'b0;
    end
    return d;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 3; i++) begin
      memLeft[i] = 0;
      brWait[i]  = 0;
      memIsLb[i] = 0;
      memBun[i]  = bubble();
      count[i]   = 0;
      cur[i]     = bubble();
    end
  endfunction

  function automatic void modelStep(int i);
    bun_t nxt;
    bun_t d;
    nxt = bubble();
    if (flushIn) begin
      memLeft[i] = 0;
      brWait[i]  = 0;
    end else if (memLeft[i] > 0) begin
      memLeft[i]--;
      if (memLeft[i] > 0) begin
        nxt    = memBun[i];
        nxt.rw = memIsLb[i] && (memLeft[i] == 1);
      end
    end else if (brWait[i]) begin
      if (brDone) brWait[i] = 0;
    end else if (instrValid) begin
      count[i]++;
      d   = refDecode(opc);
      nxt = d;
      if ((d.mr || d.mw) && mcyc[i] > 1) begin
        memLeft[i] = mcyc[i];
        memBun[i]  = d;
        memIsLb[i] = d.mr;
        nxt.rw     = 1'b0;
      end else if (d.br) begin
        brWait[i] = 1;
      end
    end
    cur[i] = nxt;
  endfunction

  function automatic bun_t gotBun(int i);
    case (i)
      0:       return {aValid, aType, aBr, aMr, aM2r, aMw, aSrc, aRw, 2'b00, aOp};
      1:       return {bValid, bType, bBr, bMr, bM2r, bMw, bSrc, bRw, bOp};
      default: return {cValid, cType, cBr, cMr, cM2r, cMw, cSrc, cRw, 2'b00, cOp};
    endcase
  endfunction

  function automatic int gotRdy(int i);
    case (i)
      0:       return int'(aRdy);
      1:       return int'(bRdy);
      default: return int'(cRdy);
    endcase
  endfunction

  function automatic int gotCnt(int i);
    case (i)
      0:       return int'(aCnt);
      1:       return int'(bCnt);
      default: return int'(cCnt);
    endcase
  endfunction

  task automatic checkVal(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, and return at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [4:0] op,
                               input logic brd, input logic fl);
    instrValid = v;
    opc        = op;
    brDone     = brd;
    flushIn    = fl;
    lowBits    = 2'($urandom);
    @(posedge clk);
    for (int i = 0; i < 3; i++) modelStep(i);
    @(negedge clk);
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("dut%0d bundle", i), int'(gotBun(i)), int'(cur[i]));
      checkVal($sformatf("dut%0d ready", i), gotRdy(i),
               int'(memLeft[i] == 0 && !brWait[i]));
      checkVal($sformatf("dut%0d count", i), gotCnt(i), count[i] & cmask[i]);
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic asyncReset();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkVal("async reset bubble", int'(gotBun(0)), int'(bubble()));
    checkVal("async reset count", gotCnt(0), 0);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[$];

  function automatic vec_t mkVec(bit v, bit [4:0] op, bit brd, bit fl,
                                 bun_t e, bit rdy, int cnt);
    vec_t r;
    r.v = v; r.op = op; r.brd = brd; r.fl = fl;
    r.exp = e; r.expRdy = rdy; r.expCnt = cnt;
    return r;
  endfunction

  initial begin
    bun_t lbB, beqB;
    lbB  = mkB(1, 2'b01, 0, 1, 1, 0, 1, 0, 4'h3);
    beqB = mkB(1, 2'b00, 1, 0, 0, 0, 1, 0, 4'hF);

    // Expected values for dut0 (MEM_CYCLES=3), one row per clock.
    vecs.push_back(mkVec(1, 5'b00000, 0, 0, mkB(1, 0, 0, 0, 0, 0, 1, 1, 4'h0), 1, 1));
    vecs.push_back(mkVec(1, 5'b00001, 0, 0, mkB(1, 0, 0, 0, 0, 0, 1, 1, 4'h1), 1, 2));
    vecs.push_back(mkVec(1, 5'b00010, 0, 0, mkB(1, 0, 0, 0, 0, 0, 0, 1, 4'h2), 1, 3));
    vecs.push_back(mkVec(1, 5'b01000, 0, 0, mkB(1, 0, 0, 0, 0, 0, 1, 1, 4'h8), 1, 4));
    vecs.push_back(mkVec(1, 5'b00011, 0, 0, lbB, 0, 5));
    vecs.push_back(mkVec(1, 5'b00000, 0, 0, lbB, 0, 5));
    vecs.push_back(mkVec(1, 5'b00000, 0, 0, mkB(1, 1, 0, 1, 1, 0, 1, 1, 4'h3), 0, 5));
    vecs.push_back(mkVec(1, 5'b00000, 0, 0, bubble(), 1, 5));
    vecs.push_back(mkVec(1, 5'b00000, 0, 0, mkB(1, 0, 0, 0, 0, 0, 1, 1, 4'h0), 1, 6));
    vecs.push_back(mkVec(1, 5'b00101, 0, 0, beqB, 0, 7));
    for (int k = 0; k < 5; k++) vecs.push_back(mkVec(0, 5'b00000, 0, 0, bubble(), 0, 7));
    vecs.push_back(mkVec(0, 5'b00000, 1, 0, bubble(), 1, 7));
    vecs.push_back(mkVec(1, 5'b10101, 0, 0, mkB(1, 3, 0, 0, 0, 0, 1, 1, 4'h5), 1, 8));
    vecs.push_back(mkVec(1, 5'b11010, 0, 0, mkB(1, 2, 0, 0, 0, 0, 1, 1, 4'h6), 1, 9));
    vecs.push_back(mkVec(1, 5'b01101, 0, 0, mkB(1, 0, 0, 0, 0, 0, 1, 0, 4'hD), 1, 10));
    vecs.push_back(mkVec(1, 5'b00110, 1, 0, beqB, 0, 11));
    vecs.push_back(mkVec(1, 5'b00000, 1, 0, bubble(), 1, 11));
    vecs.push_back(mkVec(1, 5'b00100, 0, 1, bubble(), 1, 11));
    vecs.push_back(mkVec(1, 5'b00100, 0, 0, mkB(1, 1, 0, 0, 0, 1, 1, 0, 4'h4), 0, 12));
    vecs.push_back(mkVec(0, 5'b00000, 0, 1, bubble(), 1, 12));
    vecs.push_back(mkVec(1, 5'b01111, 0, 0, mkB(1, 0, 0, 0, 0, 0, 1, 1, 4'hF), 1, 13));
    vecs.push_back(mkVec(0, 5'b00000, 0, 0, bubble(), 1, 13));

    rst_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkVal("reset bundle", int'(gotBun(0)), int'(bubble()));
    checkVal("reset ready", gotRdy(0), 1);
    checkVal("reset count", gotCnt(0), 0);
    checkOutput();

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].v, vecs[k].op, vecs[k].brd, vecs[k].fl);
      checkVal($sformatf("vec%0d bundle", k), int'(gotBun(0)), int'(vecs[k].exp));
      checkVal($sformatf("vec%0d ready", k), gotRdy(0), int'(vecs[k].expRdy));
      checkVal($sformatf("vec%0d count", k), gotCnt(0), vecs[k].expCnt);
      checkOutput();
    end

    // Reset dropped while every instance waits in a branch.
    applyStimulus(1, 5'b00101, 0, 0);
    checkOutput();
    applyStimulus(0, 5'b00000, 0, 0);
    checkOutput();
    asyncReset();

    // Counter wrap: 17 issues on a 4-bit counter leave 1.
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1, 5'b00000, 0, 0);
      checkOutput();
    end
    checkVal("wrap count dut1", int'(bCnt), 1);
    checkVal("count dut0 after 17", int'(aCnt), 17);
    applyStimulus(0, 5'b00000, 0, 0);
    checkOutput();

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        asyncReset();
      end else begin
        applyStimulus(1'($urandom_range(0, 99) < 70), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 5));
        checkOutput();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
